sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Arbitrates between the fetch stage (inst port) and the MEM stage (data port), which share one class-SRAM-style memory port (req/addr_ok/data_ok split handshake).
- Issues one request at a time and keeps an in-order owner FIFO of outstanding transactions.
- Routes each returning data_ok/rdata to the master that issued it.
- Sits between the pipeline stages and the AXI bridge.

Parameters:
- MAX_OUT, 2: maximum outstanding transactions (owner FIFO depth); legal range 1..4.
- DATA_PRIO, 1: 1 = data port wins simultaneous requests; 0 = round-robin.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  inst request
- inst_wr  in  1  inst write (normally 0)
- inst_size  in  2  inst size
- inst_wstrb  in  4  inst byte strobes
- inst_addr  in  32  inst address
- inst_wdata  in  32  inst write data
- inst_addr_ok  out  1  inst request accepted
- inst_data_ok  out  1  inst response
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master, same meanings as inst
- data_addr_ok, data_data_ok, data_rdata  out  1/1/32  data master responses
- m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/1/2/4/32/32  shared memory port request
- m_addr_ok  in  1  memory accepted request
- m_data_ok  in  1  memory response
- m_rdata  in  32  memory read data
- outstanding  out  clog2(MAX_OUT+1)  current owner-FIFO occupancy
- stray_err  out  1  sticky: m_data_ok arrived with the FIFO empty

Behaviour:
- Reset is asynchronous and active-high. Reset state: FSM IDLE, FIFO empty, outstanding=0, stray_err=0, RR pointer favours data.
- All outputs are 0 during reset, except inst_rdata/data_rdata, which mirror m_rdata.
- FSM states:
  - IDLE: no request on the memory port.
  - GRANT_I / GRANT_D: request held for that master.
- Arbitration (combinational, same cycle, IDLE only):
  - If the FIFO is full, no grant.
  - Otherwise, if only one request is present, grant it.
  - If both are present: grant data when DATA_PRIO=1; otherwise grant the side not served last.
- Lock: once granted, if m_addr_ok=0 that cycle, the FSM enters GRANT_x and holds the grant, with no re-arbitration, until m_addr_ok.
  - The master must keep its req/fields stable (class-SRAM rule).
  - In GRANT_x, m_req=1 with the muxed fields of x, even if the other master requests.
- m_req = granted master's req. The m_* request fields are muxed from the granted master and are 0 when there is no grant.
- Acceptance: x_addr_ok = m_addr_ok & m_req & grant==x; the other master's addr_ok=0.
  - On acceptance: push owner bit (0 = inst, 1 = data), update the RR pointer, return the FSM to IDLE.
  - Back-to-back issue is allowed: a new grant may be made in the cycle after acceptance.
- Full: while outstanding==MAX_OUT, no new grant and m_req=0 in IDLE.
  - An accept in the same cycle as a pop at full is not possible (no grant at full); issue resumes the cycle after the pop.
- Response routing:
  - m_data_ok with the FIFO non-empty: pop the head.
  - Head=0 → inst_data_ok=1; head=1 → data_data_ok=1 (combinational, same cycle).
  - x_rdata = m_rdata always.
  - Write responses are routed identically; data_ok is the write ack.
- Simultaneous push and pop (non-full): occupancy is unchanged and FIFO ordering is preserved. The push goes to the tail, and the pop uses the old head; if the FIFO was empty, the pop is not possible (stray).
- Stray: m_data_ok with the FIFO empty sets stray_err, which stays set until reset. Neither data_ok is asserted and the FIFO is unchanged.
- outstanding = registered FIFO count, range 0..MAX_OUT, with no wrap; FIFO pointers wrap modulo MAX_OUT.
- Reset mid-operation: the FIFO and FSM clear immediately. Responses arriving afterwards count as stray (software/bridge must be reset together).

Test Plan:
- Single inst read:
  - Stimulus: inst_req, addr 0x1c000000; m_addr_ok in the same cycle; m_data_ok 2 cycles later with rdata 0x02800413.
  - Required: inst_addr_ok=1 in cycle 0, outstanding 0→1→0, inst_data_ok=1 with inst_rdata=0x02800413, data_data_ok=0 throughout.
- Contention, DATA_PRIO=1:
  - Stimulus: inst_req and data_req both high; m_addr_ok=1.
  - Required: m_addr = data_addr, data_addr_ok=1, inst_addr_ok=0; the next cycle grants inst.
  - Repeat with DATA_PRIO=0 over 4 accepts: grants alternate D,I,D,I.
- Lock:
  - Stimulus: data granted, m_addr_ok held 0 for 3 cycles, inst_req rises in the meantime.
  - Required: m_req stays on data with m_addr constant for all 3 cycles; inst is granted only after data's addr_ok.
- Full:
  - Stimulus: MAX_OUT=2, accept inst then data with no responses, inst_req still high.
  - Required: outstanding=2, m_req=0.
  - Then m_data_ok: inst_data_ok=1 (in-order), and the inst request is issued the next cycle.
- Mixed ordering:
  - Stimulus: issue I,D,I interleaved with responses, including a push and a pop in the same cycle at outstanding=1.
  - Required: responses go to I,D,I in order, and outstanding stays 1 in the push/pop cycle.
- Stray and reset:
  - Stimulus: m_data_ok with the FIFO empty.
  - Required: stray_err=1 and no x_data_ok.
  - Then assert reset mid-outstanding (outstanding=2, asynchronous, between clock edges): outstanding=0, stray_err=0 and m_req=0 immediately.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Shares one class-SRAM memory port between the fetch (inst) and MEM (data) masters.
// It issues one request at a time and routes responses in order through an owner FIFO.
module sram_bus_arbiter #(
    parameter  int MAX_OUT   = 2,
    parameter  int DATA_PRIO = 1,
    localparam int CNT_W     = $clog2(MAX_OUT + 1),
    localparam int PTR_W     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             inst_req,
    input  logic             inst_wr,
    input  logic [1:0]       inst_size,
    input  logic [3:0]       inst_wstrb,
    input  logic [31:0]      inst_addr,
    input  logic [31:0]      inst_wdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,

    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,

    output logic             m_req,
    output logic             m_wr,
    output logic [1:0]       m_size,
    output logic [3:0]       m_wstrb,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,

    output logic [CNT_W-1:0] outstanding,
    output logic             stray_err
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t            state;
    logic              rr_last_data;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              owner [MAX_OUT];
    logic              stray_r;

    logic              full;
    logic              grant_vld;
    logic              grant_data;
    logic              sel_req;
    logic              accept;
    logic              pop;
    logic              head_owner;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count == CNT_W'(MAX_OUT));

    // Arbitration happens only in IDLE; a pending grant stays locked to its master.
    always_comb begin
        grant_vld  = 1'b0;
        grant_data = 1'b0;
        if (!reset) begin
            case (state)
                GRANT_I: begin
                    grant_vld  = 1'b1;
                    grant_data = 1'b0;
                end
                GRANT_D: begin
                    grant_vld  = 1'b1;
                    grant_data = 1'b1;
                end
                default: begin
                    if (!full) begin
                        if (inst_req && data_req) begin
                            grant_vld  = 1'b1;
                            grant_data = (DATA_PRIO != 0) ? 1'b1 : !rr_last_data;
                        end else if (data_req) begin
                            grant_vld  = 1'b1;
                            grant_data = 1'b1;
                        end else if (inst_req) begin
                            grant_vld  = 1'b1;
                            grant_data = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign sel_req = grant_data ? data_req : inst_req;
    assign m_req   = grant_vld & sel_req;
    assign m_wr    = grant_vld ? (grant_data ? data_wr    : inst_wr)    : 1'b0;
    assign m_size  = grant_vld ? (grant_data ? data_size  : inst_size)  : 2'b0;
    assign m_wstrb = grant_vld ? (grant_data ? data_wstrb : inst_wstrb) : 4'b0;
    assign m_addr  = grant_vld ? (grant_data ? data_addr  : inst_addr)  : 32'b0;
    assign m_wdata = grant_vld ? (grant_data ? data_wdata : inst_wdata) : 32'b0;

    assign accept       = m_req & m_addr_ok;
    assign inst_addr_ok = accept & !grant_data;
    assign data_addr_ok = accept &  grant_data;

    // Responses with nothing outstanding are strays and never reach a master.
    assign pop          = m_data_ok & (count != '0);
    assign head_owner   = owner[head];
    assign inst_data_ok = pop & !head_owner;
    assign data_data_ok = pop &  head_owner;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    assign outstanding  = count;
    assign stray_err    = stray_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_last_data <= 1'b0;
        end else if (accept) begin
            state        <= IDLE;
            rr_last_data <= grant_data;
        end else if (m_req) begin
            state        <= grant_data ? GRANT_D : GRANT_I;
        end else begin
            state        <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            head    <= '0;
            tail    <= '0;
            stray_r <= 1'b0;
        end else begin
            if (accept) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (m_data_ok && (count == '0)) begin
                stray_r <= 1'b1;
            end
        end
    end

    // Owner bits are payload only; validity is tracked by count/head/tail.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner[tail] <= grant_data;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a fixed-priority instance and a round-robin
// instance share the master-side inputs but have independent memory-side handshakes.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        m_addr_ok, m_data_ok, rr_m_addr_ok, rr_m_data_ok;
    logic [31:0] m_rdata;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  outstanding;
    logic        stray_err;

    logic        rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok;
    logic [31:0] rr_inst_rdata, rr_data_rdata;
    logic        rr_m_req, rr_m_wr;
    logic [1:0]  rr_m_size;
    logic [3:0]  rr_m_wstrb;
    logic [31:0] rr_m_addr, rr_m_wdata;
    logic [1:0]  rr_outstanding;
    logic        rr_stray_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUT(2), .DATA_PRIO(1)) u_dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .outstanding(outstanding), .stray_err(stray_err)
    );

    sram_bus_arbiter #(.MAX_OUT(2), .DATA_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(rr_inst_addr_ok),
        .inst_data_ok(rr_inst_data_ok), .inst_rdata(rr_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(rr_data_addr_ok),
        .data_data_ok(rr_data_data_ok), .data_rdata(rr_data_rdata),
        .m_req(rr_m_req), .m_wr(rr_m_wr), .m_size(rr_m_size), .m_wstrb(rr_m_wstrb),
        .m_addr(rr_m_addr), .m_wdata(rr_m_wdata), .m_addr_ok(rr_m_addr_ok),
        .m_data_ok(rr_m_data_ok), .m_rdata(m_rdata),
        .outstanding(rr_outstanding), .stray_err(rr_stray_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; rr_m_addr_ok = 0; rr_m_data_ok = 0;
    endtask

    initial begin
        clear_inputs();
        m_rdata = 32'h0000_0055;
        reset = 1;
        inst_req = 1; data_req = 1;
        #2;
        check("rst_m_req", m_req, 0);
        check("rst_addr_ok", inst_addr_ok | data_addr_ok, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_stray", stray_err, 0);
        check("rst_rdata_mirror", inst_rdata, 32'h55);
        check("rst_m_addr", m_addr, 0);
        #10;
        reset = 0;
        clear_inputs();
        tick();

        // single inst read
        inst_req = 1; inst_addr = 32'h1c00_0000; m_addr_ok = 1;
        #1;
        check("t1_m_req", m_req, 1);
        check("t1_m_addr", m_addr, 32'h1c00_0000);
        check("t1_inst_addr_ok", inst_addr_ok, 1);
        check("t1_data_addr_ok", data_addr_ok, 0);
        check("t1_out0", outstanding, 0);
        tick();
        inst_req = 0; m_addr_ok = 0;
        #1;
        check("t1_out1", outstanding, 1);
        check("t1_no_resp_yet", inst_data_ok, 0);
        tick();
        m_data_ok = 1; m_rdata = 32'h0280_0413;
        #1;
        check("t1_inst_data_ok", inst_data_ok, 1);
        check("t1_inst_rdata", inst_rdata, 32'h0280_0413);
        check("t1_data_data_ok", data_data_ok, 0);
        tick();
        m_data_ok = 0;
        #1;
        check("t1_out_end", outstanding, 0);

        // contention with data priority
        inst_req = 1; inst_addr = 32'h1c00_0100;
        data_req = 1; data_addr = 32'h8000_0010; data_wr = 1; data_wstrb = 4'hf;
        data_wdata = 32'hdead_beef; m_addr_ok = 1;
        #1;
        check("t2_m_addr_d", m_addr, 32'h8000_0010);
        check("t2_m_wr", m_wr, 1);
        check("t2_m_wdata", m_wdata, 32'hdead_beef);
        check("t2_data_addr_ok", data_addr_ok, 1);
        check("t2_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 0; data_wr = 0;
        #1;
        check("t2_m_addr_i", m_addr, 32'h1c00_0100);
        check("t2_m_wr_i", m_wr, 0);
        check("t2_inst_addr_ok2", inst_addr_ok, 1);
        check("t2_out1", outstanding, 1);
        tick();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1;
        check("t2_out2", outstanding, 2);
        check("t2_resp_d", data_data_ok, 1);
        check("t2_resp_d_inst", inst_data_ok, 0);
        tick();
        #1;
        check("t2_resp_i", inst_data_ok, 1);
        tick();
        m_data_ok = 0;
        #1;
        check("t2_out_end", outstanding, 0);

        // lock: data held for three cycles without addr_ok, inst arrives meanwhile
        data_req = 1; data_addr = 32'h8000_0020;
        #1;
        check("t3_c0_m_req", m_req, 1);
        check("t3_c0_m_addr", m_addr, 32'h8000_0020);
        tick();
        inst_req = 1; inst_addr = 32'h1c00_0200;
        #1;
        check("t3_c1_m_addr", m_addr, 32'h8000_0020);
        check("t3_c1_inst_ok", inst_addr_ok, 0);
        tick();
        #1;
        check("t3_c2_m_addr", m_addr, 32'h8000_0020);
        check("t3_c2_m_req", m_req, 1);
        tick();
        m_addr_ok = 1;
        #1;
        check("t3_d_addr_ok", data_addr_ok, 1);
        check("t3_i_addr_ok0", inst_addr_ok, 0);
        tick();
        data_req = 0;
        #1;
        check("t3_i_m_addr", m_addr, 32'h1c00_0200);
        check("t3_i_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1;
        check("t3_resp_d", data_data_ok, 1);
        tick();
        #1;
        check("t3_resp_i", inst_data_ok, 1);
        tick();
        m_data_ok = 0;

        // full
        inst_req = 1; inst_addr = 32'h1c00_0300; m_addr_ok = 1;
        #1;
        check("t4_i_addr_ok", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h1c00_0304; data_req = 1; data_addr = 32'h8000_0030;
        #1;
        check("t4_d_addr_ok", data_addr_ok, 1);
        tick();
        data_req = 0;
        #1;
        check("t4_full_out", outstanding, 2);
        check("t4_full_m_req", m_req, 0);
        check("t4_full_i_ok", inst_addr_ok, 0);
        tick();
        m_data_ok = 1;
        #1;
        check("t4_pop_inst", inst_data_ok, 1);
        check("t4_pop_data", data_data_ok, 0);
        check("t4_pop_m_req", m_req, 0);
        tick();
        m_data_ok = 0;
        #1;
        check("t4_resume_out", outstanding, 1);
        check("t4_resume_addr", m_addr, 32'h1c00_0304);
        check("t4_resume_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1;
        check("t4_drain_d", data_data_ok, 1);
        tick();
        #1;
        check("t4_drain_i", inst_data_ok, 1);
        tick();
        m_data_ok = 0;
        #1;
        check("t4_out_end", outstanding, 0);

        // mixed ordering with push/pop in the same cycle
        inst_req = 1; inst_addr = 32'h1c00_0400; m_addr_ok = 1;
        #1;
        check("t5_i_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h8000_0040; m_data_ok = 1;
        #1;
        check("t5_d_ok", data_addr_ok, 1);
        check("t5_resp1_i", inst_data_ok, 1);
        check("t5_resp1_d", data_data_ok, 0);
        tick();
        #1;
        check("t5_out_pushpop", outstanding, 1);
        data_req = 0; inst_req = 1; inst_addr = 32'h1c00_0404;
        #1;
        check("t5_i2_ok", inst_addr_ok, 1);
        check("t5_resp2_d", data_data_ok, 1);
        check("t5_resp2_i", inst_data_ok, 0);
        tick();
        inst_req = 0; m_addr_ok = 0;
        #1;
        check("t5_out_pushpop2", outstanding, 1);
        check("t5_resp3_i", inst_data_ok, 1);
        tick();
        m_data_ok = 0;
        #1;
        check("t5_out_end", outstanding, 0);

        // stray response, then async reset with two outstanding
        m_data_ok = 1;
        #1;
        check("t6_stray_no_i", inst_data_ok, 0);
        check("t6_stray_no_d", data_data_ok, 0);
        tick();
        m_data_ok = 0;
        #1;
        check("t6_stray_err", stray_err, 1);
        check("t6_stray_out", outstanding, 0);
        inst_req = 1; inst_addr = 32'h1c00_0500; m_addr_ok = 1;
        tick();
        tick();
        #1;
        check("t6_pre_rst_out", outstanding, 2);
        check("t6_pre_rst_stray", stray_err, 1);
        #1;
        reset = 1;
        #1;
        check("t6_rst_out", outstanding, 0);
        check("t6_rst_stray", stray_err, 0);
        check("t6_rst_m_req", m_req, 0);
        tick();
        clear_inputs();
        reset = 0;
        #1;

        // round-robin instance: four accepts with both masters requesting
        inst_req = 1; inst_addr = 32'h1c00_0600;
        data_req = 1; data_addr = 32'h8000_0060;
        rr_m_addr_ok = 1;
        #1;
        check("t7_rr0_d", rr_data_addr_ok, 1);
        check("t7_rr0_i", rr_inst_addr_ok, 0);
        tick();
        rr_m_data_ok = 1;
        #1;
        check("t7_rr1_i", rr_inst_addr_ok, 1);
        check("t7_rr1_d", rr_data_addr_ok, 0);
        check("t7_rr1_resp_d", rr_data_data_ok, 1);
        tick();
        #1;
        check("t7_rr2_d", rr_data_addr_ok, 1);
        check("t7_rr2_resp_i", rr_inst_data_ok, 1);
        tick();
        #1;
        check("t7_rr3_i", rr_inst_addr_ok, 1);
        check("t7_rr3_m_addr", rr_m_addr, 32'h1c00_0600);
        check("t7_rr_out", rr_outstanding, 1);
        tick();
        clear_inputs();
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
